// File: rtl/canvas_addr_gen_scaled.sv
// Raster-to-canvas address generator with runtime origin/zoom.
// Config changes are double-buffered and applied at the start of vblank.
module canvas_addr_gen_scaled #(
    parameter int CANVAS_W   = 28,
    parameter int CANVAS_H   = 28,
    parameter int CNT_W      = 10,
    parameter int ADDR_W     = 10,
    parameter int MAX_SHIFT  = 5,
    parameter int DEF_SHIFT  = 4,
    parameter int DEF_X0     = 0,
    parameter int DEF_Y0     = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIPE_EXTRA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  h_cnt,
    input  logic [CNT_W-1:0]  v_cnt,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_shift,
    input  logic [CNT_W-1:0]  cfg_x0,
    input  logic [CNT_W-1:0]  cfg_y0,
    input  logic [ADDR_W-1:0] cursor_addr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              in_canvas,
    output logic              grid_line,
    output logic              cursor_hit,
    output logic              frame_start
);

    localparam int EXT_W = CNT_W + MAX_SHIFT + 5;
    localparam int PW    = ADDR_W + 3;

    logic [2:0]       act_shift;
    logic [CNT_W-1:0] act_x0;
    logic [CNT_W-1:0] act_y0;
    logic [2:0]       sh_shift;
    logic [CNT_W-1:0] sh_x0;
    logic [CNT_W-1:0] sh_y0;
    logic             pending;

    logic             boundary;
    logic             accept;
    logic [2:0]       clamped;

    assign cfg_ready = !pending;
    assign accept    = cfg_valid && !pending;
    assign boundary  = (h_cnt == '0) && (v_cnt == CNT_W'(V_ACTIVE));
    assign clamped   = (cfg_shift > 3'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : cfg_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_shift <= 3'(DEF_SHIFT);
            act_x0    <= CNT_W'(DEF_X0);
            act_y0    <= CNT_W'(DEF_Y0);
            sh_shift  <= '0;
            sh_x0     <= '0;
            sh_y0     <= '0;
            pending   <= 1'b0;
        end else begin
            // accept only happens with pending low, so the two never collide
            if (boundary && pending) begin
                act_shift <= sh_shift;
                act_x0    <= sh_x0;
                act_y0    <= sh_y0;
                pending   <= 1'b0;
            end
            if (accept) begin
                sh_shift <= clamped;
                sh_x0    <= cfg_x0;
                sh_y0    <= cfg_y0;
                pending  <= 1'b1;
            end
        end
    end

    logic [EXT_W-1:0] h_ext;
    logic [EXT_W-1:0] v_ext;
    logic [EXT_W-1:0] x0_ext;
    logic [EXT_W-1:0] y0_ext;
    logic [EXT_W-1:0] x_end;
    logic [EXT_W-1:0] y_end;
    logic [EXT_W-1:0] dx;
    logic [EXT_W-1:0] dy;
    logic [EXT_W-1:0] col;
    logic [EXT_W-1:0] row;
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] addr_full;
    logic             in_x;
    logic             in_y;
    logic             in_next;
    logic             grid_next;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        h_ext     = EXT_W'(h_cnt);
        v_ext     = EXT_W'(v_cnt);
        x0_ext    = EXT_W'(act_x0);
        y0_ext    = EXT_W'(act_y0);
        x_end     = x0_ext + (EXT_W'(CANVAS_W) << act_shift);
        y_end     = y0_ext + (EXT_W'(CANVAS_H) << act_shift);
        in_x      = (h_ext >= x0_ext) && (h_ext < x_end)
                    && (h_ext < EXT_W'(H_ACTIVE));
        in_y      = (v_ext >= y0_ext) && (v_ext < y_end)
                    && (v_ext < EXT_W'(V_ACTIVE));
        in_next   = in_x && in_y;
        dx        = h_ext - x0_ext;
        dy        = v_ext - y0_ext;
        col       = dx >> act_shift;
        row       = dy >> act_shift;
        mask      = (EXT_W'(1) << act_shift) - EXT_W'(1);
        addr_full = row * EXT_W'(CANVAS_W) + col;
        addr_next = in_next ? addr_full[ADDR_W-1:0] : '0;
        grid_next = in_next
                    && (((dx & mask) == '0) || ((dy & mask) == '0));
    end

    // word layout: {frame_start, grid_line, in_canvas, pixel_addr}
    logic [PIPE_EXTRA:0][PW-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {boundary && pending, grid_next, in_next, addr_next};
            for (int i = 1; i <= PIPE_EXTRA; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign pixel_addr  = pipe[PIPE_EXTRA][ADDR_W-1:0];
    assign in_canvas   = pipe[PIPE_EXTRA][ADDR_W];
    assign grid_line   = pipe[PIPE_EXTRA][ADDR_W+1];
    assign frame_start = pipe[PIPE_EXTRA][ADDR_W+2];
    assign cursor_hit  = in_canvas && (pixel_addr == cursor_addr);

endmodule

// File: tb/tb_canvas_addr_gen_scaled.sv
// Scoreboard bench: PIPE_EXTRA=0 and PIPE_EXTRA=2 instances share stimulus
// and are checked against an arithmetic reference model.
module tb_canvas_addr_gen_scaled;

    logic       clk = 0;
    logic       rst;
    logic [9:0] h_cnt, v_cnt, cfg_x0, cfg_y0, cursor_addr;
    logic       cfg_valid;
    logic [2:0] cfg_shift;

    logic       rdy0, ic0, gl0, ch0, fs0;
    logic [9:0] pa0;
    logic       rdy2, ic2, gl2, ch2, fs2;
    logic [9:0] pa2;

    always #5 clk = ~clk;

    canvas_addr_gen_scaled #(.PIPE_EXTRA(0)) u_p0 (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_shift(cfg_shift),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cursor_addr(cursor_addr),
        .pixel_addr(pa0), .in_canvas(ic0), .grid_line(gl0),
        .cursor_hit(ch0), .frame_start(fs0)
    );

    canvas_addr_gen_scaled #(.PIPE_EXTRA(2)) u_p2 (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .cfg_valid(cfg_valid), .cfg_ready(rdy2), .cfg_shift(cfg_shift),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cursor_addr(cursor_addr),
        .pixel_addr(pa2), .in_canvas(ic2), .grid_line(gl2),
        .cursor_hit(ch2), .frame_start(fs2)
    );

    typedef struct {
        int due;
        int addr;
        bit inc;
        bit grid;
        bit fs;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // reference model state
    int m_shift, m_x0, m_y0, s_shift, s_x0, s_y0;
    bit m_pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input exp_t e, input int pa,
                           input bit ic, input bit gl, input bit ch,
                           input bit fs);
        chk({nm, ".pixel_addr"}, pa, e.addr);
        chk({nm, ".in_canvas"}, int'(ic), int'(e.inc));
        chk({nm, ".grid_line"}, int'(gl), int'(e.grid));
        chk({nm, ".frame_start"}, int'(fs), int'(e.fs));
        chk({nm, ".cursor_hit"}, int'(ch),
            int'(e.inc && (e.addr == int'(cursor_addr))));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            chk_out("p0", e, int'(pa0), ic0, gl0, ch0, fs0);
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            e = q2.pop_front();
            chk_out("p2", e, int'(pa2), ic2, gl2, ch2, fs2);
        end
    end

    task automatic model_reset();
        m_shift = 4; m_x0 = 0; m_y0 = 16;
        s_shift = 0; s_x0 = 0; s_y0 = 0;
        m_pend = 0;
    endtask

    function automatic exp_t model_out(input int h, input int v);
        exp_t e;
        int sc, col, row;
        sc = 1 << m_shift;
        e.due = 0;
        e.inc = (h >= m_x0) && (h < m_x0 + 28 * sc) && (h < 640)
             && (v >= m_y0) && (v < m_y0 + 28 * sc) && (v < 480);
        e.addr = 0;
        e.grid = 0;
        if (e.inc) begin
            col = (h - m_x0) / sc;
            row = (v - m_y0) / sc;
            e.addr = (row * 28 + col) % 1024;
            e.grid = ((h - m_x0) % sc == 0) || ((v - m_y0) % sc == 0);
        end
        e.fs = (h == 0) && (v == 480) && m_pend;
        return e;
    endfunction

    task automatic step(input int h, input int v, input bit vld = 0,
                        input int sh = 0, input int x = 0, input int y = 0);
        exp_t e;
        bit was_pend;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        cfg_valid = vld;
        cfg_shift = 3'(sh);
        cfg_x0 = 10'(x);
        cfg_y0 = 10'(y);
        chk("p0.cfg_ready", int'(rdy0), int'(!m_pend));
        chk("p2.cfg_ready", int'(rdy2), int'(!m_pend));
        e = model_out(h, v);
        e.due = cyc + 1;
        q0.push_back(e);
        e.due = cyc + 3;
        q2.push_back(e);
        was_pend = m_pend;
        if (h == 0 && v == 480 && was_pend) begin
            m_shift = s_shift; m_x0 = s_x0; m_y0 = s_y0;
            m_pend = 0;
        end
        if (vld && !was_pend) begin
            s_shift = (sh > 5) ? 5 : sh;
            s_x0 = x; s_y0 = y;
            m_pend = 1;
        end
        @(posedge clk);
        #1;
        cfg_valid = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".p0.pixel_addr"}, int'(pa0), 0);
        chk({nm, ".p0.in_canvas"}, int'(ic0), 0);
        chk({nm, ".p0.grid_line"}, int'(gl0), 0);
        chk({nm, ".p0.cursor_hit"}, int'(ch0), 0);
        chk({nm, ".p0.frame_start"}, int'(fs0), 0);
        chk({nm, ".p0.cfg_ready"}, int'(rdy0), 1);
        chk({nm, ".p2.pixel_addr"}, int'(pa2), 0);
        chk({nm, ".p2.in_canvas"}, int'(ic2), 0);
        chk({nm, ".p2.frame_start"}, int'(fs2), 0);
        chk({nm, ".p2.cfg_ready"}, int'(rdy2), 1);
    endtask

    task automatic rand_steps(input int n, input bit allow_cfg);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                step(0, 480);
            end else if (allow_cfg && $urandom_range(0, 19) == 0) begin
                step($urandom_range(0, 799), $urandom_range(0, 524), 1,
                     $urandom_range(0, 7), $urandom_range(0, 400),
                     $urandom_range(0, 300));
            end else begin
                step($urandom_range(0, 799), $urandom_range(0, 524));
            end
            if ($urandom_range(0, 29) == 0)
                cursor_addr = 10'($urandom_range(0, 783));
        end
    endtask

    initial begin
        rst = 1;
        h_cnt = 0; v_cnt = 0; cfg_valid = 0; cfg_shift = 0;
        cfg_x0 = 0; cfg_y0 = 0; cursor_addr = 10'd29;
        model_reset();
        #3;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 0;

        // default mapping corners
        step(447, 463);
        step(448, 463);
        step(100, 15);
        step(16, 32);
        step(17, 33);

        // cursor block scan around cell 29
        for (int v = 30; v < 50; v++)
            for (int h = 12; h < 36; h++)
                step(h, v);

        rand_steps(300, 0);

        // mid-frame config, back-pressure, then apply at boundary
        step(5, 100, 1, 3, 100, 50);
        step(16, 32);
        step(20, 40, 1, 2, 7, 7);
        step(447, 463);
        step(0, 480);
        step(143, 66);
        step(324, 66);
        step(323, 273);
        rand_steps(100, 0);

        // clamping of oversize shift
        step(9, 9, 1, 7, 3, 1);
        step(0, 480);
        step(3, 1);
        step(899 - 800 + 3, 33);
        rand_steps(100, 0);

        // handshake on the boundary cycle itself
        step(0, 480, 1, 0, 10, 20);
        step(10, 20);
        step(37, 47);
        step(0, 480);
        step(10, 20);
        step(37, 47);
        step(38, 47);
        rand_steps(100, 0);

        // long randomized run with random configs
        rand_steps(2000, 1);

        // reset mid-frame with a pending config
        step(0, 480);
        step(5, 100, 1, 2, 30, 40);
        step(200, 200);
        rst = 1;
        #1;
        chk_zero("midreset");
        q0.delete();
        q2.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        step(0, 480);
        step(447, 463);
        step(30, 40);
        rand_steps(200, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", q0.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
